// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, Bridge base
// address and the layout of the VEC read-back register.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PEND = 3'd0;
    localparam logic [2:0] IRQ_MASK = 3'd1;
    localparam logic [2:0] IRQ_MODE = 3'd2;
    localparam logic [2:0] IRQ_CTRL = 3'd3;
    localparam logic [2:0] IRQ_VEC  = 3'd4;

    // Bits [4:2] of the base are zero so offsets can be OR-ed in.
    localparam logic [31:0] IRQ_BASE_ADDR = 32'h0000_7F20;

    localparam int VEC_VALID_BIT = 31;
    localparam int IRQ_HW_W      = 6;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } irq_vec_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bridge-side register bus of the interrupt controller (word access, block pre-selected).
interface irq_ctrl_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered set request (index 0 wins).
import irq_ctrl_pkg::*;

module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req_i,
    output irq_vec_t     vec_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        vec_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vec_o.valid = 1'b1;
                vec_o.idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises Src into HWInt.
// Define IRQ_SYNC_EN to pass Src through a 2-flop synchroniser (asynchronous sources).
import irq_ctrl_pkg::*;

module irq_ctrl #(
    parameter int          NSRC     = 6,
    parameter logic [5:0]  MODE_RST = 6'b000000,
    parameter logic [5:0]  MASK_RST = 6'b000000
) (
    input  logic            clk,
    input  logic            reset,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] Src,
    output logic [5:0]      HWInt
);

    logic [NSRC-1:0] src_s;

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= Src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = Src;
`endif

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] src_q;
    logic            gen_q, gen_d;
    logic [5:0]      hwint_q, hwint_d;

    logic [2:0]      reg_sel;
    logic            wr_pend, wr_mask, wr_mode, wr_ctrl;
    logic [NSRC-1:0] rise;
    irq_vec_t        vec;
    logic [31:0]     dout;
    logic            unused_bits;

    assign reg_sel = bus.Addr[4:2];
    assign wr_pend = bus.WE && (reg_sel == IRQ_PEND);
    assign wr_mask = bus.WE && (reg_sel == IRQ_MASK);
    assign wr_mode = bus.WE && (reg_sel == IRQ_MODE);
    assign wr_ctrl = bus.WE && (reg_sel == IRQ_CTRL);

    assign rise        = src_s & ~src_q;
    assign unused_bits = ^{bus.Addr[31:5], bus.Addr[1:0], bus.Din[31:NSRC]};

    // Edge bits: a rise beats a simultaneous W1C so no interrupt is lost.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) begin
                if (rise[i])
                    pend_d[i] = 1'b1;
                else if (wr_pend && bus.Din[i])
                    pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = src_s[i];
            end
        end
    end

    always_comb begin
        mask_d = wr_mask ? bus.Din[NSRC-1:0] : mask_q;
        mode_d = wr_mode ? bus.Din[NSRC-1:0] : mode_q;
        gen_d  = wr_ctrl ? bus.Din[0]        : gen_q;
    end

    always_comb begin
        hwint_d           = '0;
        hwint_d[NSRC-1:0] = {NSRC{gen_q}} & pend_q & mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= MASK_RST[NSRC-1:0];
            mode_q  <= MODE_RST[NSRC-1:0];
            gen_q   <= 1'b0;
            hwint_q <= '0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            gen_q   <= gen_d;
            hwint_q <= hwint_d;
        end
    end

    // Sampled through reset so a source already high at release is not seen as a rise.
    always_ff @(posedge clk) begin
        src_q <= src_s;
    end

    irq_prio_enc #(.N(NSRC)) u_prio (
        .req_i (pend_q & mask_q),
        .vec_o (vec)
    );

    always_comb begin
        dout = '0;
        case (reg_sel)
            IRQ_PEND: dout[NSRC-1:0] = pend_q;
            IRQ_MASK: dout[NSRC-1:0] = mask_q;
            IRQ_MODE: dout[NSRC-1:0] = mode_q;
            IRQ_CTRL: dout[0]        = gen_q;
            IRQ_VEC: begin
                if (vec.valid) begin
                    dout[VEC_VALID_BIT] = 1'b1;
                    dout[2:0]           = vec.idx;
                end
            end
            default: dout = '0;
        endcase
    end

    assign bus.Dout = dout;
    assign HWInt    = hwint_q;

endmodule
